// File: rtl/sweep_ctrl_if.sv
// Control/config and sinegen-drive signals of the frequency-sweep scheduler.
// The master side supplies sweep requests; the slave side is sweep_ctrl.
interface sweep_ctrl_if #(
    parameter int D_WIDTH     = 8,
    parameter int DWELL_WIDTH = 16
);
    logic                   start;
    logic                   abort;
    logic                   mode;
    logic [D_WIDTH-1:0]     f_lo;
    logic [D_WIDTH-1:0]     f_hi;
    logic [D_WIDTH-1:0]     f_step;
    logic [DWELL_WIDTH-1:0] dwell;
    logic                   en;
    logic [D_WIDTH-1:0]     incr;
    logic                   busy;
    logic                   done;
    logic                   cfg_err;

    modport master (
        output start, abort, mode, f_lo, f_hi, f_step, dwell,
        input  en, incr, busy, done, cfg_err
    );

    modport slave (
        input  start, abort, mode, f_lo, f_hi, f_step, dwell,
        output en, incr, busy, done, cfg_err
    );
endinterface

// File: rtl/sweep_ctrl.sv
// Frequency-sweep scheduler: steps sinegen's phase increment between two bounds,
// holding each value for a programmable dwell (single up-sweep or continuous triangle).
module sweep_ctrl #(
    parameter int D_WIDTH     = 8,
    parameter int DWELL_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    sweep_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

    state_t                 r_state,   w_state;
    logic                   r_en,      w_en;
    logic                   r_busy,    w_busy;
    logic                   r_done,    w_done;
    logic                   r_cfg_err, w_cfg_err;
    logic                   r_pend,    w_pend;
    logic                   r_mode,    w_mode;
    logic [D_WIDTH-1:0]     r_incr,    w_incr;
    logic [D_WIDTH-1:0]     r_lo,      w_lo;
    logic [D_WIDTH-1:0]     r_hi,      w_hi;
    logic [D_WIDTH-1:0]     r_step,    w_step;
    logic [DWELL_WIDTH-1:0] r_cnt,     w_cnt;
    logic [DWELL_WIDTH-1:0] r_reload,  w_reload;

    // Sum carried in D_WIDTH+1 bits so a step near the top of range clamps instead of wrapping.
    function automatic logic [D_WIDTH-1:0] sat_up(input logic [D_WIDTH-1:0] a,
                                                  input logic [D_WIDTH-1:0] s,
                                                  input logic [D_WIDTH-1:0] lim);
        logic [D_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, s};
        if (sum > {1'b0, lim}) return lim;
        return sum[D_WIDTH-1:0];
    endfunction

    function automatic logic [D_WIDTH-1:0] sat_dn(input logic [D_WIDTH-1:0] a,
                                                  input logic [D_WIDTH-1:0] s,
                                                  input logic [D_WIDTH-1:0] lim);
        logic signed [D_WIDTH+1:0] diff;
        diff = $signed({2'b00, a}) - $signed({2'b00, s});
        if (diff < $signed({2'b00, lim})) return lim;
        return diff[D_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_pend    <= 1'b0;
            r_mode    <= 1'b0;
            r_incr    <= '0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_step    <= '0;
            r_cnt     <= '0;
            r_reload  <= '0;
        end else begin
            r_state   <= w_state;
            r_en      <= w_en;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_cfg_err <= w_cfg_err;
            r_pend    <= w_pend;
            r_mode    <= w_mode;
            r_incr    <= w_incr;
            r_lo      <= w_lo;
            r_hi      <= w_hi;
            r_step    <= w_step;
            r_cnt     <= w_cnt;
            r_reload  <= w_reload;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_en      = r_en;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_cfg_err = 1'b0;
        w_pend    = r_pend;
        w_mode    = r_mode;
        w_incr    = r_incr;
        w_lo      = r_lo;
        w_hi      = r_hi;
        w_step    = r_step;
        w_cnt     = r_cnt;
        w_reload  = r_reload;

        case (r_state)
            IDLE: begin
                w_en   = 1'b0;
                w_busy = 1'b0;
                // Config is latched on the accept edge and validated one cycle later.
                if (bus.abort) begin
                    w_pend = 1'b0;
                end else if (r_pend) begin
                    w_pend = 1'b0;
                    if ((r_lo > r_hi) || (r_step == '0)) begin
                        w_cfg_err = 1'b1;
                    end else begin
                        w_state = UP;
                        w_en    = 1'b1;
                        w_busy  = 1'b1;
                        w_incr  = r_lo;
                        w_cnt   = r_reload;
                    end
                end else if (bus.start) begin
                    w_pend   = 1'b1;
                    w_mode   = bus.mode;
                    w_lo     = bus.f_lo;
                    w_hi     = bus.f_hi;
                    w_step   = bus.f_step;
                    w_reload = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_WIDTH'(1);
                end
            end
            UP, DOWN: begin
                if (bus.abort) begin
                    w_state = IDLE;
                    w_en    = 1'b0;
                    w_busy  = 1'b0;
                end else if (r_cnt != '0) begin
                    w_cnt = r_cnt - DWELL_WIDTH'(1);
                end else begin
                    w_cnt = r_reload;
                    if (r_state == UP) begin
                        if (r_incr < r_hi) begin
                            w_incr = sat_up(r_incr, r_step, r_hi);
                        end else if (!r_mode) begin
                            w_state = DONE;
                            w_en    = 1'b0;
                            w_busy  = 1'b0;
                            w_done  = 1'b1;
                        end else begin
                            w_state = DOWN;
                            w_incr  = sat_dn(r_incr, r_step, r_lo);
                        end
                    end else begin
                        if (r_incr > r_lo) begin
                            w_incr = sat_dn(r_incr, r_step, r_lo);
                        end else begin
                            w_state = UP;
                            w_incr  = sat_up(r_lo, r_step, r_hi);
                        end
                    end
                end
            end
            DONE: begin
                w_state = IDLE;
                w_en    = 1'b0;
                w_busy  = 1'b0;
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.en      = r_en;
    assign bus.incr    = r_incr;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.cfg_err = r_cfg_err;
endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
- Frequency-sweep scheduler that drives the `en` and `incr` inputs of `sinegen`.
- Steps the phase increment from a low to a high bound, holding each value for a programmable dwell.
- Mode 0: single up-sweep. Mode 1: continuous triangle (up/down) sweep.
- Sits between the control/config inputs and `sinegen`. It turns the fixed-tone generator into a chirp source.

Parameters:
- D_WIDTH, 8: width of the frequency increment; matches the `incr` width of `sinegen`.
- DWELL_WIDTH, 16: width of the dwell-cycle count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep; sampled only in IDLE.
- abort  in  1  stops the sweep; returns to IDLE, no done pulse.
- mode  in  1  0 = single up-sweep, 1 = continuous up/down.
- f_lo  in  D_WIDTH  start/lower increment.
- f_hi  in  D_WIDTH  upper increment.
- f_step  in  D_WIDTH  increment change per step.
- dwell  in  DWELL_WIDTH  cycles held at each increment; 0 is treated as 1.
- en  out  1  enable to `sinegen`.
- incr  out  D_WIDTH  phase increment to `sinegen`.
- busy  out  1  high in UP/DOWN.
- done  out  1  one-cycle pulse at the end of a mode-0 sweep.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-sweep):
  - state = IDLE.
  - en, incr, busy, done and cfg_err all 0.
  - dwell counter 0; latched configuration cleared.
- All outputs are registered.
- States: IDLE, UP, DOWN, DONE.
- IDLE:
  - en = 0; incr holds its last value.
  - On start with abort low, latch f_lo, f_hi, f_step, dwell and mode.
  - If f_lo > f_hi or f_step == 0: cfg_err = 1 for the next cycle only; stay in IDLE.
  - Otherwise, on the next cycle: state = UP, en = 1, busy = 1, incr = f_lo, dwell counter = max(dwell,1) - 1.
- Dwell:
  - The counter decrements each cycle in UP/DOWN.
  - Expiry is the cycle the counter equals 0. It reloads to max(dwell,1) - 1 on every incr change.
  - Each increment value is presented with en = 1 for exactly max(dwell,1) cycles.
- UP, on expiry:
  - If incr < f_hi: incr = min(incr + f_step, f_hi). Compute the sum in D_WIDTH+1 bits; no wrap. f_hi is always visited.
  - If incr == f_hi and mode = 0: go to DONE.
  - If incr == f_hi and mode = 1: go to DOWN with incr = max(incr - f_step, f_lo). Compute as a signed/extended subtraction; no underflow.
- DOWN, on expiry:
  - If incr > f_lo: incr = max(incr - f_step, f_lo).
  - If incr == f_lo: go to UP with incr = min(f_lo + f_step, f_hi).
- Degenerate case f_lo == f_hi: mode 0 holds one value, then goes to DONE. Mode 1 holds the constant indefinitely.
- DONE (one cycle): en = 0, busy = 0, done = 1, incr holds f_hi. Then IDLE.
- abort in UP/DOWN:
  - Next cycle: IDLE, en = 0, busy = 0, no done.
  - Abort has priority over dwell expiry.
  - In IDLE, abort suppresses a same-cycle start.
- start while busy or in DONE is ignored. Configuration inputs are ignored outside the start-accept cycle; changing them mid-sweep has no effect.
- Latency: start accepted at edge N gives en = 1 and incr = f_lo after edge N+1.

Test Plan:
- Reset: assert rst mid-UP, asynchronously between edges → en, incr, busy and done read 0 before the next edge. Release, then start → a sweep begins cleanly from f_lo.
- Single sweep: mode 0, f_lo = 10, f_hi = 40, f_step = 10, dwell = 3 → incr 10, 20, 30, 40, each with en = 1 for 3 cycles (12 total). Then done = 1 for one cycle and busy falls in that same cycle.
- Clamp: mode 0, f_lo = 10, f_hi = 35, f_step = 10, dwell = 0 → incr 10, 20, 30, 35, one cycle each, then done.
- Triangle at the top of range: mode 1, f_lo = 250, f_hi = 255, f_step = 4, dwell = 1 → incr 250, 254, 255, 251, 250, 254, 255, … with no wrap past 255 or below 250; done never pulses.
- Config error: f_lo = 50, f_hi = 20 → cfg_err one-cycle pulse, busy stays 0, en stays 0. Same result for f_step = 0.
- Abort and ignored start: mode 1 sweep, pulse start while busy → no restart. Assert abort during DOWN on an expiry cycle → IDLE next cycle, en = 0, no done, incr holds its value.
